// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: 4-digit multiplexed 7-segment scan scheduler.
// Walks the four digit slots, blanks the anodes at the start of every slot
// to avoid ghosting, and double-buffers the displayed BCD value so a new
// number is only swapped in at a frame boundary.
module disp_scan_ctrl #(
  parameter int TICK_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  input  logic [15:0] wr_data,
  output logic        wr_ready,
  input  logic        lz_blank,
  input  logic [3:0]  dp_sel,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_done
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_BLK = CW'(BLANK_CYC);

  logic [CW-1:0] cnt;
  logic [1:0]    sel;
  logic [15:0]   active;
  logic [15:0]   shadow;
  logic          pending;

  logic          slot_end;
  logic          boundary;
  logic          accept;
  logic          in_blank;
  logic [3:0]    cur_digit;
  logic [3:0]    suppress;
  logic          blank_now;

  assign slot_end = (cnt == CNT_MAX);
  assign boundary = slot_end && (sel == 2'd3);
  assign accept   = wr_valid && wr_ready;
  // With BLANK_CYC=0 the whole slot is driven.
  assign in_blank = (BLANK_CYC != 0) && (cnt < CNT_BLK);

  // Slot timer and digit selector; sel advances on the last cycle of a slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sel <= 2'd0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) sel <= sel + 2'd1;
    end
  end

  // Double buffer: accept into shadow, move to active only at a frame boundary.
  // An accept needs pending=0 and a transfer needs pending=1, so they never
  // collide; a boundary-cycle accept waits for the following boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= 16'h0000;
      shadow   <= 16'h0000;
      pending  <= 1'b0;
      wr_ready <= 1'b1;
    end else if (accept) begin
      shadow   <= wr_data;
      pending  <= 1'b1;
      wr_ready <= 1'b0;
    end else if (boundary && pending) begin
      active   <= shadow;
      pending  <= 1'b0;
      wr_ready <= 1'b1;
    end
  end

  // Current digit mux and leading-zero suppression mask (digit0 always shown).
  always_comb begin
    cur_digit   = active[3:0];
    case (sel)
      2'd0: cur_digit = active[3:0];
      2'd1: cur_digit = active[7:4];
      2'd2: cur_digit = active[11:8];
      2'd3: cur_digit = active[15:12];
      default: cur_digit = active[3:0];
    endcase
    suppress    = 4'b0000;
    suppress[3] = lz_blank && (active[15:12] == 4'h0);
    suppress[2] = suppress[3] && (active[11:8] == 4'h0);
    suppress[1] = suppress[2] && (active[7:4] == 4'h0);
    blank_now   = in_blank || suppress[sel];
  end

  // Registered display outputs, one cycle behind the slot timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= 4'b1111;
      digit      <= 4'hF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (blank_now) begin
        an    <= 4'b1111;
        digit <= 4'hF;
        dp    <= 1'b1;
      end else begin
        an    <= ~(4'b0001 << sel);
        digit <= cur_digit;
        dp    <= ~dp_sel[sel];
      end
    end
  end

endmodule
